regfile_mp: RTL and testbench

//  Parametrised multi-port register file for the pipelined core. Successor to the 2R/1W file.

---
 rtl/rf_pkg.sv | 25 ++
 rtl/rf_read_port.sv | 48 ++++
 rtl/regfile_mp.sv | 105 ++++++++++
 tb/tb_regfile_mp.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// ============================================================================
// Module   : rf_pkg
// Brief    : Shared state encodings and helpers for the multi-port register file.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package rf_pkg;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } rf_state_e;

    // Ceiling log2, floored at 1 so a single-entry file still gets an address bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rf_read_port.sv
// ============================================================================
// Module   : rf_read_port
// Brief    : One combinational read port: range/zero checks, write bypass, storage mux.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_read_port #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int DEPTH    = 32,
    parameter int NW       = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       ready_i,
    input  logic [AW-1:0]              ra_i,
    input  logic [NW-1:0]              wvalid_i,
    input  logic [NW*AW-1:0]           wa_i,
    input  logic [NW*DW-1:0]           wd_i,
    input  logic [DEPTH-1:0][DW-1:0]   mem_i,
    output logic [DW-1:0]              rd_o
);

    logic w_in_range;
    logic w_is_zero;

    assign w_in_range = (32'(ra_i) < DEPTH);
    assign w_is_zero  = (ZERO_REG != 0) && (ra_i == '0);

    // Ascending scan lets the highest-index matching write port win.
    always_comb begin
        rd_o = '0;
        if (ready_i && w_in_range && !w_is_zero) begin
            rd_o = mem_i[ra_i];
            if (BYPASS != 0) begin
                for (int k = 0; k < NW; k++) begin
                    if (wvalid_i[k] && (wa_i[k*AW +: AW] == ra_i)) begin
                        rd_o = wd_i[k*DW +: DW];
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module   : regfile_mp
// Brief    : Parametrised NR-read / NW-write register file with reset clear sweep.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_mp
    import rf_pkg::*;
#(
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int NR       = 2,
    parameter int NW       = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int AW       = clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NW-1:0]        we,
    input  logic [NW*AW-1:0]     wa,
    input  logic [NW*DW-1:0]     wd,
    input  logic [NR*AW-1:0]     ra,
    output logic [NR*DW-1:0]     rd,
    output logic                 init_busy
);

    localparam logic [AW:0] PTR_LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    rf_state_e                  state_q, state_d;
    logic [AW:0]                ptr_q, ptr_d;
    logic [DEPTH-1:0][DW-1:0]   mem_q;
    logic [NW-1:0]              w_wvalid;
    logic                       w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == S_CLEAR) begin
            ptr_d = ptr_q + PTR_ONE;
            if (ptr_q == PTR_LAST) begin
                state_d = S_READY;
            end
        end
    end

    assign w_ready   = (state_q == S_READY);
    assign init_busy = (state_q == S_CLEAR);

    // A write is valid only when ready, in range, and not aimed at a hardwired zero.
    for (genvar k = 0; k < NW; k++) begin : g_wdec
        assign w_wvalid[k] = w_ready && we[k]
                          && (32'(wa[k*AW +: AW]) < DEPTH)
                          && !((ZERO_REG != 0) && (wa[k*AW +: AW] == '0));
    end

    // Later loop iterations override earlier ones, so the highest port wins collisions.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_CLEAR) begin
                mem_q[ptr_q[AW-1:0]] <= '0;
            end else begin
                for (int k = 0; k < NW; k++) begin
                    if (w_wvalid[k]) begin
                        mem_q[wa[k*AW +: AW]] <= wd[k*DW +: DW];
                    end
                end
            end
        end
    end

    for (genvar j = 0; j < NR; j++) begin : g_rd
        rf_read_port #(
            .DW       (DW),
            .AW       (AW),
            .DEPTH    (DEPTH),
            .NW       (NW),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd (
            .ready_i  (w_ready),
            .ra_i     (ra[j*AW +: AW]),
            .wvalid_i (w_wvalid),
            .wa_i     (wa),
            .wd_i     (wd),
            .mem_i    (mem_q),
            .rd_o     (rd[j*DW +: DW])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Two register-file configurations driven in lockstep against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic [9:0]  ra;
    logic [63:0] rd_a, rd_b;
    logic        busy_a, busy_b;

    int n_cmp = 0;
    int n_err = 0;

    // Config A: 32 entries, bypass on.  Config B: 24 entries, bypass off.
    regfile_mp #(.DW(32), .DEPTH(32), .NR(2), .NW(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_a), .init_busy(busy_a)
    );

    regfile_mp #(.DW(32), .DEPTH(24), .NR(2), .NW(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_b), .init_busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] mmem [2][32];
    int          mdep [2] = '{32, 24};
    bit          mbyp [2] = '{1'b1, 1'b0};
    bit          mbusy[2];
    int          mrem [2];
    bit          model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            model_valid = 1'b1;
            for (int d = 0; d < 2; d++) begin
                mbusy[d] = 1'b1;
                mrem[d]  = mdep[d];
                for (int i = 0; i < 32; i++) mmem[d][i] = '0;
            end
        end else if (model_valid) begin
            for (int d = 0; d < 2; d++) begin
                if (mbusy[d]) begin
                    mrem[d]--;
                    if (mrem[d] == 0) mbusy[d] = 1'b0;
                end else begin
                    for (int k = 0; k < 2; k++) begin
                        if (we[k] && int'(wa[k*5 +: 5]) < mdep[d] && wa[k*5 +: 5] != 5'd0)
                            mmem[d][wa[k*5 +: 5]] = wd[k*32 +: 32];
                    end
                end
            end
        end
    end

    function automatic logic [31:0] exp_rd(input int d, input logic [4:0] a);
        if (mbusy[d] || int'(a) >= mdep[d] || a == 5'd0) return '0;
        if (mbyp[d]) begin
            if (we[1] && wa[9:5] == a) return wd[63:32];
            if (we[0] && wa[4:0] == a) return wd[31:0];
        end
        return mmem[d][a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            for (int j = 0; j < 2; j++) begin
                chk($sformatf("model rd_a[%0d]", j), rd_a[j*32 +: 32], exp_rd(0, ra[j*5 +: 5]));
                chk($sformatf("model rd_b[%0d]", j), rd_b[j*32 +: 32], exp_rd(1, ra[j*5 +: 5]));
            end
            chk("model busy_a", {31'd0, busy_a}, {31'd0, mbusy[0]});
            chk("model busy_b", {31'd0, busy_b}, {31'd0, mbusy[1]});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Counts cycles each file stays busy after rst has been released; bounded.
    task automatic count_sweep(output int ca, output int cb);
        ca = 0;
        cb = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_a) ca++;
            if (busy_b) cb++;
            if (!busy_a && !busy_b) break;
            tick();
        end
    endtask

    int ca, cb;

    initial begin
        rst = 1'b1; we = '0; wa = '0; wd = '0; ra = '0;
        tick(); tick();

        // T1: sweep length and ignored write during the sweep
        rst = 1'b0;
        we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'h0000_DEAD}; ra = {5'd0, 5'd5};
        count_sweep(ca, cb);
        we = '0;
        chk("T1 sweep cycles A", 32'(ca), 32'd32);
        chk("T1 sweep cycles B", 32'(cb), 32'd24);
        #1;
        chk("T1 r5 after sweep A", rd_a[31:0], 32'h0);
        chk("T1 r0 after sweep A", rd_a[63:32], 32'h0);

        // T2: basic write/read and hardwired zero
        we = 2'b01; wa = {5'd0, 5'd7}; wd = {32'd0, 32'h1234_5678}; ra = {5'd0, 5'd7};
        tick();
        we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'd0, 32'hFFFF_FFFF}; ra = {5'd0, 5'd7};
        #1;
        chk("T2 r7 A", rd_a[31:0], 32'h1234_5678);
        chk("T2 r7 B", rd_b[31:0], 32'h1234_5678);
        tick();
        we = '0;
        #1;
        chk("T2 r0 A", rd_a[63:32], 32'h0);
        chk("T2 r0 B", rd_b[63:32], 32'h0);

        // T3: bypass on A, old value then new value on B
        we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'd0, 32'hA5A5_A5A5}; ra = {5'd0, 5'd9};
        #1;
        chk("T3 bypass A", rd_a[31:0], 32'hA5A5_A5A5);
        chk("T3 old B", rd_b[31:0], 32'h0);
        tick();
        we = '0;
        #1;
        chk("T3 new B", rd_b[31:0], 32'hA5A5_A5A5);

        // T4: two ports collide on r3
        we = 2'b11; wa = {5'd3, 5'd3}; wd = {32'h0000_2222, 32'h0000_1111}; ra = {5'd3, 5'd3};
        #1;
        chk("T4 bypass A", rd_a[31:0], 32'h0000_2222);
        tick();
        we = '0;
        #1;
        chk("T4 r3 A", rd_a[31:0], 32'h0000_2222);
        chk("T4 r3 B", rd_b[63:32], 32'h0000_2222);

        // T6: out-of-range on B, address 30 is valid on A; r23 is B's last entry
        we = 2'b11; wa = {5'd23, 5'd30}; wd = {32'h2323_0000, 32'h0000_BEEF}; ra = {5'd23, 5'd30};
        tick();
        we = '0;
        #1;
        chk("T6 a30 B", rd_b[31:0], 32'h0);
        chk("T6 r23 B", rd_b[63:32], 32'h2323_0000);
        chk("T6 a30 A", rd_a[31:0], 32'h0000_BEEF);

        // T5: reset mid-sweep restarts the full sweep and wipes r7
        ra = {5'd30, 5'd7};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_sweep(ca, cb);
        chk("T5 sweep cycles A", 32'(ca), 32'd32);
        chk("T5 sweep cycles B", 32'(cb), 32'd24);
        #1;
        chk("T5 r7 A", rd_a[31:0], 32'h0);
        chk("T5 r7 B", rd_b[31:0], 32'h0);
        chk("T5 a30 A", rd_a[63:32], 32'h0);

        // Post-reset writes still work with the other port
        we = 2'b10; wa = {5'd12, 5'd0}; wd = {32'hCAFE_F00D, 32'd0}; ra = {5'd12, 5'd12};
        tick();
        we = '0;
        #1;
        chk("T5 r12 A", rd_a[31:0], 32'hCAFE_F00D);
        chk("T5 r12 B", rd_b[63:32], 32'hCAFE_F00D);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
